unit_rate_rr_sched: RTL and testbench

- Round-robin scheduler that shares one combinational unit-rate actor (e.g. the 32-bit increment actor) between NUM_REQ valid/ready requester channels.
- Each cycle it grants at most one requester and drives that requester's operand into the shared actor.
- The actor's result is captured in a one-entry output register, together with the requester index.
- Sits between the producer-side dataflow fabric and the shared arithmetic actor in generated top-level modules.

---
 rtl/unit_rate_rr_sched.sv | 108 ++++++++++
 tb/tb_unit_rate_rr_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/unit_rate_rr_sched.sv
// Round-robin scheduler sharing one combinational unit-rate actor among NUM_REQ requesters.
// Optional saturating backpressure counter on stall_cnt: define UNIT_RATE_RR_SCHED_STALL_CNT_EN.
//
// state | meaning
// ------+---------------------------------------
// EMPTY | output register has no result
// FULL  | output register holds a result
module unit_rate_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         act_arg,
  output logic                      act_arg_valid,
  input  logic [DATA_W-1:0]         act_ret,
  input  logic                      act_ret_valid,
  output logic [DATA_W-1:0]         res_data,
  output logic [TAG_W-1:0]          res_tag,
  output logic                      res_valid,
`ifdef UNIT_RATE_RR_SCHED_STALL_CNT_EN
  output logic [15:0]               stall_cnt,
`endif
  input  logic                      res_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [TAG_W-1:0]   rr_ptr;
  logic [TAG_W-1:0]   ptr_nxt;
  logic [TAG_W-1:0]   g;
  logic               grant;
  logic               capture;
  logic               can_issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      res_data <= '0;
      res_tag  <= '0;
      rr_ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        res_data <= act_ret;
        res_tag  <= g;
        rr_ptr   <= ptr_nxt;
      end
    end
  end

  assign res_valid = (state == FULL);

  always_comb begin
    int idx;
    idx           = 0;
    state_nxt     = state;
    grant         = 1'b0;
    g             = '0;
    capture       = 1'b0;
    act_arg       = '0;
    act_arg_valid = 1'b0;
    req_ready     = '0;
    can_issue     = (state == EMPTY) | res_ready;

    // Reset suppresses any grant so a held result is simply dropped.
    if (!rst && can_issue) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!grant && req_valid[idx]) begin
          grant = 1'b1;
          g     = TAG_W'(idx);
        end
      end
    end

    if (grant) begin
      act_arg       = req_data[32'(g)*DATA_W +: DATA_W];
      act_arg_valid = 1'b1;
      req_ready[g]  = act_ret_valid;
      capture       = act_ret_valid;
    end

    if (capture)
      state_nxt = FULL;
    else if ((state == FULL) && res_ready)
      state_nxt = EMPTY;
  end

  assign ptr_nxt = (g == TAG_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;

`ifdef UNIT_RATE_RR_SCHED_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (res_valid && !res_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_unit_rate_rr_sched.sv
// Directed bench for unit_rate_rr_sched with a +1 actor model and a result scoreboard.
module tb_unit_rate_rr_sched;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   act_arg;
  logic           act_arg_valid;
  logic [W-1:0]   act_ret;
  logic           act_ret_valid;
  logic [W-1:0]   res_data;
  logic [1:0]     res_tag;
  logic           res_valid;
  logic           res_ready;
`ifdef UNIT_RATE_RR_SCHED_STALL_CNT_EN
  logic [15:0]    stall_cnt;
  int             stall_model = 0;
`endif

  always #5 clk = ~clk;

  assign act_ret       = act_arg + 32'd1;
  assign act_ret_valid = act_arg_valid;

  unit_rate_rr_sched #(.NUM_REQ(N), .DATA_W(W), .TAG_W(2)) dut (
    .clk(clk), .rst(rst),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .act_arg(act_arg), .act_arg_valid(act_arg_valid),
    .act_ret(act_ret), .act_ret_valid(act_ret_valid),
    .res_data(res_data), .res_tag(res_tag), .res_valid(res_valid),
`ifdef UNIT_RATE_RR_SCHED_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .res_ready(res_ready)
  );

  typedef struct packed {
    logic [1:0]  tag;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   ptr_model = 0;
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_data(input int i, input logic [31:0] v);
    req_data[i*W +: W] = v;
  endtask

  // One cycle: checks at the falling edge, then steps the model and returns after the rising edge.
  task automatic cyc();
    bit          full, can, gnt;
    int          g;
    logic [31:0] opd;
    @(negedge clk);
    full = (q.size() != 0);
    chk("res_valid", 64'(res_valid), 64'(full));
    if (full) begin
      chk("res_data", 64'(res_data), 64'(q[0].data));
      chk("res_tag", 64'(res_tag), 64'(q[0].tag));
    end
`ifdef UNIT_RATE_RR_SCHED_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(stall_model));
`endif
    if (rst) begin
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_act_valid", 64'(act_arg_valid), 64'(0));
      q.delete();
      ptr_model = 0;
`ifdef UNIT_RATE_RR_SCHED_STALL_CNT_EN
      stall_model = 0;
`endif
    end else begin
      can = !full || res_ready;
      gnt = 1'b0;
      g   = 0;
      if (can) begin
        for (int k = 0; k < N; k++) begin
          if (!gnt && req_valid[(ptr_model + k) % N]) begin
            gnt = 1'b1;
            g   = (ptr_model + k) % N;
          end
        end
      end
      opd = gnt ? req_data[g*W +: W] : 32'd0;
      chk("req_ready", 64'(req_ready), gnt ? 64'(1) << g : 64'(0));
      chk("act_arg_valid", 64'(act_arg_valid), 64'(gnt));
      chk("act_arg", 64'(act_arg), 64'(opd));
`ifdef UNIT_RATE_RR_SCHED_STALL_CNT_EN
      if (full && !res_ready && stall_model < 16'hFFFF) stall_model++;
`endif
      if (full && res_ready) void'(q.pop_front());
      if (gnt) begin
        q.push_back('{tag: 2'(g), data: opd + 32'd1});
        ptr_model = (g + 1) % N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    res_ready = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, 32'(100 + i));
    #1;

    // Reset held for two cycles with every requester asserting valid.
    cyc();
    cyc();
    chk("reset_res_data", 64'(res_data), 64'(0));
    chk("reset_res_tag", 64'(res_tag), 64'(0));
    rst = 1'b0;
    cyc();
    chk("first_grant_tag", 64'(res_tag), 64'(0));
    req_valid = '0;
    cyc();

    // Single requester 2.
    req_valid = 4'b0100;
    set_data(2, 32'd41);
    cyc();
    chk("single_data", 64'(res_data), 64'd42);
    chk("single_tag", 64'(res_tag), 64'd2);

    // rr_ptr now 3; overflow wrap through requester 3.
    req_valid = 4'b1000;
    set_data(3, 32'h7FFF_FFFF);
    cyc();
    chk("ovf_data", 64'(res_data), 64'h8000_0000);
    chk("ovf_tag", 64'(res_tag), 64'd3);
    chk("ovf_ptr_wrap", 64'(ptr_model), 64'd0);

    // Fairness: all valid, full throughput.
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < N; i++) set_data(i, $urandom);
      cyc();
      chk("fair_tag_seq", 64'(res_tag), 64'(c % N));
    end

    // Backpressure for five cycles.
    req_valid = 4'b0011;
    res_ready = 1'b0;
    for (int c = 0; c < 5; c++) cyc();
`ifdef UNIT_RATE_RR_SCHED_STALL_CNT_EN
    chk("stall_cnt_5", 64'(stall_cnt), 64'd5);
`endif
    res_ready = 1'b1;
    cyc();
    chk("bp_release_tag", 64'(res_tag), 64'd0);

    // Mid-operation reset while FULL and stalled.
    res_ready = 1'b0;
    rst       = 1'b1;
    cyc();
    rst       = 1'b0;
    res_ready = 1'b1;
    req_valid = 4'b1111;
    cyc();
    chk("midrst_cleared_then_tag0", 64'(res_tag), 64'd0);
    req_valid = '0;
    cyc();
    cyc();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
